// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO and its environment.
package fifo_pkg;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] fifo_data_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered read port; only the read register resets.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int AW     = ptr_w(fifo_pkg::DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Same-address read and write returns the old word (read-before-write).
  always_ff @(posedge clk)
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and error pulses around fifo_mem.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W       = fifo_pkg::DATA_W,
  parameter int DEPTH        = fifo_pkg::DEPTH,
  parameter int ALM_FULL_TH  = 2,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_wren,
  input  logic                       i_rden,
  input  logic [DATA_W-1:0]          i_wrdata,
  output logic                       o_full,
  output logic                       o_alm_full,
  output logic                       o_empty,
  output logic                       o_alm_empty,
  output logic [DATA_W-1:0]          o_rddata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wr_err,
  output logic                       o_rd_err
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          rd_acc, wr_acc;

  // Acceptance looks only at registered flags, so no input reaches an output combinationally.
  assign rd_acc = i_rden && !o_empty;
  assign wr_acc = i_wren && (!o_full || rd_acc);

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      o_full      <= 1'b0;
      o_alm_full  <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_empty <= 1'b1;
      o_wr_err    <= 1'b0;
      o_rd_err    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_q     <= count_nxt;
      // Flags track the next count so they line up with o_count.
      o_full      <= (count_nxt == CW'(DEPTH));
      o_alm_full  <= (count_nxt >= CW'(DEPTH - ALM_FULL_TH));
      o_empty     <= (count_nxt == '0);
      o_alm_empty <= (count_nxt <= CW'(ALM_EMPTY_TH));
      o_wr_err    <= i_wren && !wr_acc;
      o_rd_err    <= i_rden && o_empty;
    end
  end

  assign o_count = count_q;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .rstn (rstn),
    .we   (wr_acc && rstn),
    .waddr(wr_ptr),
    .wdata(i_wrdata),
    .re   (rd_acc),
    .raddr(rd_ptr),
    .rdata(o_rddata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based occupancy model.
module tb_sync_fifo;
  import fifo_pkg::*;
  localparam int DW = 128, DEPTH = 16, AFT = 2, AET = 2;

  logic clk = 1'b0, rstn = 1'b0, i_wren = 1'b0, i_rden = 1'b0;
  logic [DW-1:0] i_wrdata = '0;
  logic o_full, o_alm_full, o_empty, o_alm_empty, o_wr_err, o_rd_err;
  logic [DW-1:0] o_rddata;
  logic [$clog2(DEPTH):0] o_count;

  sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(AFT), .ALM_EMPTY_TH(AET)) dut (
    .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_rden(i_rden), .i_wrdata(i_wrdata),
    .o_full(o_full), .o_alm_full(o_alm_full), .o_empty(o_empty), .o_alm_empty(o_alm_empty),
    .o_rddata(o_rddata), .o_count(o_count), .o_wr_err(o_wr_err), .o_rd_err(o_rd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: contents as a queue, flags derived from its size.
  fifo_data_t q[$];
  fifo_data_t m_rd = '0;
  bit m_werr = 1'b0, m_rerr = 1'b0;

  always @(posedge clk) begin : model
    int n;
    bit ra, wa;
    n = q.size();
    if (!rstn) begin
      q.delete();
      m_rd = '0; m_werr = 1'b0; m_rerr = 1'b0;
    end else begin
      ra = i_rden && (n > 0);
      wa = i_wren && ((n < DEPTH) || ra);
      m_werr = i_wren && !wa;
      m_rerr = i_rden && (n == 0);
      if (ra) m_rd = q.pop_front();
      if (wa) q.push_back(i_wrdata);
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("count",     o_count,     q.size());
    chk("full",      o_full,      q.size() == DEPTH);
    chk("alm_full",  o_alm_full,  q.size() >= DEPTH - AFT);
    chk("empty",     o_empty,     q.size() == 0);
    chk("alm_empty", o_alm_empty, q.size() <= AET);
    chk("rddata",    o_rddata,    m_rd);
    chk("wr_err",    o_wr_err,    m_werr);
    chk("rd_err",    o_rd_err,    m_rerr);
  end

  task automatic drv(input bit rn, input bit w, input bit r, input logic [DW-1:0] d);
    @(negedge clk);
    rstn = rn; i_wren = w; i_rden = r; i_wrdata = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    drv(1'b1, w, r, d);
  endtask

  initial begin
    logic [DW-1:0] rnd;
    int pw, pr;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (3) cyc(0, 0, '0);
    chk("idle_empty", o_empty, 1'b1);
    chk("idle_alm_empty", o_alm_empty, 1'b1);
    chk("idle_full", o_full, 1'b0);
    chk("idle_alm_full", o_alm_full, 1'b0);
    chk("idle_count", o_count, 0);
    chk("idle_rddata", o_rddata, 0);

    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, DW'(i));
      if (i == 2)  chk("alm_empty_at2", o_alm_empty, 1'b1);
      if (i == 3)  chk("alm_empty_at3", o_alm_empty, 1'b0);
      if (i == 13) chk("alm_full_at13", o_alm_full, 1'b0);
      if (i == 14) chk("alm_full_at14", o_alm_full, 1'b1);
      if (i == 15) chk("full_at15", o_full, 1'b0);
    end
    chk("full_at16", o_full, 1'b1);
    chk("count16", o_count, 16);
    cyc(1, 0, 'h11);
    chk("wr_err_full", o_wr_err, 1'b1);
    chk("count_stays16", o_count, 16);
    cyc(0, 0, '0);
    chk("wr_err_drop", o_wr_err, 1'b0);

    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, '0);
      chk("drain_data", o_rddata, DW'(i));
    end
    chk("drain_empty", o_empty, 1'b1);
    cyc(0, 1, '0);
    chk("rd_err_empty", o_rd_err, 1'b1);
    chk("rddata_hold", o_rddata, 'h10);

    for (int i = 0; i < 16; i++) cyc(1, 0, DW'('h200 + i));
    cyc(1, 1, 'hAA);
    chk("full_rw_count", o_count, 16);
    chk("full_rw_wr_err", o_wr_err, 1'b0);
    chk("full_rw_rd", o_rddata, 'h200);
    for (int i = 0; i < 16; i++) cyc(0, 1, '0);
    chk("aa_last", o_rddata, 'hAA);

    cyc(1, 1, 'h55);
    chk("empty_rw_rd_err", o_rd_err, 1'b1);
    chk("empty_rw_count", o_count, 1);
    cyc(0, 1, '0);
    chk("empty_rw_data", o_rddata, 'h55);

    for (int i = 0; i < 10; i++) cyc(1, 0, DW'('h300 + i));
    for (int i = 0; i < 10; i++) cyc(0, 1, '0);
    for (int i = 0; i < 12; i++) cyc(1, 0, DW'('h400 + i));
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, '0);
      chk("wrap_data", o_rddata, DW'('h400 + i));
    end

    for (int i = 0; i < 5; i++) cyc(1, 0, DW'('h500 + i));
    drv(1'b0, 1, 1, 'h5FF);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_wr_err", o_wr_err, 1'b0);
    chk("rst_rd_err", o_rd_err, 1'b0);
    cyc(0, 1, '0);
    chk("post_rst_rd_err", o_rd_err, 1'b1);
    chk("post_rst_rddata", o_rddata, 0);
    cyc(1, 0, 'h600);
    cyc(0, 1, '0);
    chk("post_rst_data", o_rddata, 'h600);

    pw = 50; pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drv($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rnd);
    end
    cyc(0, 0, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
